mux_arbiter: RTL and testbench

Shares one W-bit output channel between N_REQ requesters by sequencing the select of an internal N_REQ-to-1 multiplexer. Each requester raises `req` with its data; the arbiter picks one winner, registers the winner's data onto a valid/ready output, and acknowledges the winner when the downstream consumer accepts it. It sits between several producer blocks and a single shared consumer, for example a display or serial sink, in the combinational/sequential exercise set.

---
 rtl/mux_arbiter.sv | 99 +++++++++
 tb/tb_mux_arbiter.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/mux_arbiter.sv
// rtl/mux_arbiter.sv - N_REQ-to-1 muxing arbiter onto a registered valid/ready channel
// MUX_ARB_ROUND_ROBIN_EN selects round-robin priority; undefined gives fixed lowest-index priority.
module mux_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*W-1:0]       data,
    output logic [N_REQ-1:0]         gnt,
    output logic                     out_valid,
    output logic [W-1:0]             out_data,
    input  logic                     out_ready,
    output logic [$clog2(N_REQ)-1:0] grant_id
);

    localparam int IW = $clog2(N_REQ);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t        state;
    logic [IW-1:0] winner;
    logic          found;

`ifdef MUX_ARB_ROUND_ROBIN_EN
    logic [IW-1:0] ptr;

    // Scan starting at ptr and wrap, so the previous winner drops to lowest priority.
    always_comb begin
        int idx;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N_REQ) idx = idx - N_REQ;
            if (!found && req[idx]) begin
                winner = IW'(idx);
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!found && req[i]) begin
                winner = IW'(i);
                found  = 1'b1;
            end
        end
    end
`endif

    // out_valid is only high in HOLD, so this is the sole out_ready->gnt path.
    always_comb begin
        gnt = '0;
        if (out_valid && out_ready) gnt[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            grant_id  <= '0;
`ifdef MUX_ARB_ROUND_ROBIN_EN
            ptr       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        out_data  <= data[int'(winner)*W +: W];
                        grant_id  <= winner;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
`ifdef MUX_ARB_ROUND_ROBIN_EN
                        if (grant_id == IW'(N_REQ-1)) ptr <= '0;
                        else                          ptr <= grant_id + 1'b1;
`endif
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux_arbiter.sv
// tb/tb_mux_arbiter.sv - directed self-checking bench for mux_arbiter
module tb_mux_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   gnt;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_ready;
    logic [1:0]     grant_id;

    int errors = 0;
    int checks = 0;

    mux_arbiter #(.N_REQ(N), .W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .gnt(gnt),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

`ifdef MUX_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    initial begin
        int exp_id;
        rst = 1'b1; req = '0; data = '0; out_ready = 1'b0;
        tick(); tick();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data",  32'(out_data), 0);
        check("rst_id",    32'(grant_id), 0);
        check("rst_gnt",   32'(gnt), 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_valid", 32'(out_valid), 0);
            check("idle_gnt",   32'(gnt), 0);
            check("idle_data",  32'(out_data), 0);
        end

        // single requester, ready high
        req = 4'b0100; data[2*W +: W] = 8'hA5; out_ready = 1'b1;
        tick();
        check("single_valid", 32'(out_valid), 1);
        check("single_data",  32'(out_data), 32'hA5);
        check("single_id",    32'(grant_id), 2);
        check("single_gnt",   32'(gnt), 32'b0100);
        req = '0;
        tick();
        check("single_idle", 32'(out_valid), 0);

        // ptr is now 3 under round-robin: 1100 picks 3 there, 2 under fixed priority
        req = 4'b1100; data[3*W +: W] = 8'h77;
        tick();
        exp_id = RR ? 3 : 2;
        check("ptr_probe_id",  32'(grant_id), 32'(exp_id));
        check("ptr_probe_gnt", 32'(gnt), 32'(1 << exp_id));
        req = '0;
        tick();

        // backpressure with data change during stall
        out_ready = 1'b0; req = 4'b0001; data[0 +: W] = 8'h3C;
        tick();
        check("bp_valid", 32'(out_valid), 1);
        check("bp_id",    32'(grant_id), 0);
        data[0 +: W] = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_data",  32'(out_data), 32'h3C);
            check("bp_gnt",   32'(gnt), 0);
            check("bp_hold",  32'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_gnt_rise", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        check("bp_idle", 32'(out_valid), 0);

        // fairness from a fresh pointer
        rst = 1'b1; #1; rst = 1'b0;
        req = 4'b1111; out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_id = RR ? (i % 4) : 0;
            tick();
            check("rr_valid", 32'(out_valid), 1);
            check("rr_id",    32'(grant_id), 32'(exp_id));
            check("rr_gnt",   32'(gnt), 32'(1 << exp_id));
            tick();
            check("rr_gap_valid", 32'(out_valid), 0);
            check("rr_gap_gnt",   32'(gnt), 0);
        end
        req = 4'b1110;
        tick();
        check("drop0_id",  32'(grant_id), 1);
        check("drop0_gnt", 32'(gnt), 32'b0010);
        req = '0;
        tick();

        // reset mid-transfer
        out_ready = 1'b0; req = 4'b0010; data[1*W +: W] = 8'h5A;
        tick();
        check("mid_id",    32'(grant_id), 1);
        check("mid_valid", 32'(out_valid), 1);
        #2; rst = 1'b1; #1;
        check("mid_rst_valid", 32'(out_valid), 0);
        check("mid_rst_gnt",   32'(gnt), 0);
        #1; rst = 1'b0;
        check("mid_rst_gnt2",  32'(gnt), 0);
        tick();
        check("restart_valid", 32'(out_valid), 1);
        check("restart_id",    32'(grant_id), 1);
        check("restart_data",  32'(out_data), 32'h5A);
        check("restart_gnt0",  32'(gnt), 0);
        out_ready = 1'b1; #1;
        check("restart_gnt",   32'(gnt), 32'b0010);
        req = '0;
        tick();
        check("final_idle", 32'(out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
